tc_stream: RTL and testbench

TC_STREAM -- requirements
Module: tc_stream

---
 rtl/tc_stream.sv | 158 +++++++++++++++
 tb/tb_tc_stream.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/tc_stream.sv
// tc_stream: counts the bit transitions in each incoming word, using a
// two-stage valid/ready pipeline, and keeps a saturating running total.
//
// Ports
//   CLK        clock; all state changes on its rising edge
//   Clear      asynchronous active-low reset
//   Load       input valid; a word is accepted when Load & Ready
//   Ready      input ready
//   Data [W]   word to count; bit 0 is the first bit in the stream
//   Mode [2]   00 any, 01 rising, 10 falling, 11 any plus the boundary from the previous word
//   Acc_en     add this word's count to Total
//   Flush      synchronous clear of Total, Sat and the chain history
//   Valid      result valid
//   Out_ready  result consumed when Valid & Out_ready
//   Count [CW] transition count of the presented result
//   Total [AW] saturating running sum of the accumulated counts
//   Sat        sticky saturation flag
module tc_stream #(
   parameter int unsigned W  = 10,
   parameter int unsigned AW = 16,
   localparam int unsigned CW = $clog2(W + 1)
) (
   input  logic          CLK,
   input  logic          Clear,
   input  logic          Load,
   output logic          Ready,
   input  logic [W-1:0]  Data,
   input  logic [1:0]    Mode,
   input  logic          Acc_en,
   input  logic          Flush,
   output logic          Valid,
   input  logic          Out_ready,
   output logic [CW-1:0] Count,
   output logic [AW-1:0] Total,
   output logic          Sat
);

   // The sum must hold Total plus the largest count without wrapping.
   localparam int unsigned SW = ((AW > CW) ? AW : CW) + 1;

   // run_q holds Ready low until the first edge after reset release.
   logic          run_q;

   // History of the last accepted word's MSB, used by chain mode.
   logic          hist_q, hist_vld_q;

   // Stage 1
   logic          s1_vld_q;
   logic [W-1:0]  s1_data_q;
   logic [1:0]    s1_mode_q;
   logic          s1_acc_q;
   logic          s1_hist_q, s1_hvld_q;

   // Output stage
   logic          out_vld_q;
   logic [CW-1:0] count_q;
   logic [AW-1:0] total_q, total_d;
   logic          sat_q, sat_d;

   logic          adv, accept;
   logic [W-2:0]  sel;
   logic [CW-1:0] count_d;
   logic [SW-1:0] sum;

   assign adv    = s1_vld_q & (~out_vld_q | Out_ready);
   assign Ready  = run_q & (~s1_vld_q | adv);
   assign accept = Load & Ready;

   // Pair classification and population count for the word in stage 1.
   always_comb begin
      sel = '0;
      case (s1_mode_q)
         2'b01:   sel = ~s1_data_q[W-2:0] &  s1_data_q[W-1:1];
         2'b10:   sel =  s1_data_q[W-2:0] & ~s1_data_q[W-1:1];
         default: sel =  s1_data_q[W-2:0] ^  s1_data_q[W-1:1];
      endcase
      count_d = '0;
      for (int i = 0; i < W - 1; i++) begin
         count_d = count_d + CW'(sel[i]);
      end
      // Chain mode also counts the boundary between the previous word and this one.
      if (s1_mode_q == 2'b11 && s1_hvld_q && (s1_hist_q != s1_data_q[0])) begin
         count_d = count_d + CW'(1'b1);
      end
   end

   // Saturating accumulate; Flush takes priority over an accumulation in the same cycle.
   always_comb begin
      sum     = SW'(total_q) + SW'(count_d);
      total_d = total_q;
      sat_d   = sat_q;
      if (Flush) begin
         total_d = '0;
         sat_d   = 1'b0;
      end else if (adv && s1_acc_q) begin
         if (sum > {{(SW - AW){1'b0}}, {AW{1'b1}}}) begin
            total_d = '1;
            sat_d   = 1'b1;
         end else begin
            total_d = sum[AW-1:0];
         end
      end
   end

   always_ff @(posedge CLK or negedge Clear) begin
      if (!Clear) begin
         run_q      <= 1'b0;
         hist_q     <= 1'b0;
         hist_vld_q <= 1'b0;
         s1_vld_q   <= 1'b0;
         s1_data_q  <= '0;
         s1_mode_q  <= '0;
         s1_acc_q   <= 1'b0;
         s1_hist_q  <= 1'b0;
         s1_hvld_q  <= 1'b0;
         out_vld_q  <= 1'b0;
         count_q    <= '0;
         total_q    <= '0;
         sat_q      <= 1'b0;
      end else begin
         run_q   <= 1'b1;
         total_q <= total_d;
         sat_q   <= sat_d;

         if (accept) begin
            s1_vld_q   <= 1'b1;
            s1_data_q  <= Data;
            s1_mode_q  <= Mode;
            s1_acc_q   <= Acc_en;
            s1_hist_q  <= hist_q;
            // A simultaneous Flush hides the old history from this word.
            s1_hvld_q  <= hist_vld_q & ~Flush;
            hist_q     <= Data[W-1];
            hist_vld_q <= 1'b1;
         end else begin
            if (adv) begin
               s1_vld_q <= 1'b0;
            end
            if (Flush) begin
               hist_vld_q <= 1'b0;
            end
         end

         if (adv) begin
            out_vld_q <= 1'b1;
            count_q   <= count_d;
         end else if (Out_ready) begin
            out_vld_q <= 1'b0;
         end
      end
   end

   assign Valid = out_vld_q;
   assign Count = count_q;
   assign Total = total_q;
   assign Sat   = sat_q;

endmodule

// File: tb/tb_tc_stream.sv
// Directed bench for tc_stream: a default instance (W=10, AW=16) and an AW=4 instance
// share all inputs, so saturation can be seen on the narrow accumulator.
module tb_tc_stream;

   logic       CLK = 1'b0;
   logic       Clear = 1'b0;
   logic       Load = 1'b0;
   logic [9:0] Data = '0;
   logic [1:0] Mode = '0;
   logic       Acc_en = 1'b0;
   logic       Flush = 1'b0;
   logic       Out_ready = 1'b1;

   logic        Ready, Valid, Sat;
   logic [3:0]  Count;
   logic [15:0] Total;

   logic        ready4, valid4, sat4;
   logic [3:0]  count4;
   logic [3:0]  total4;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [9:0] ALT = 10'b0101010101;

   tc_stream #(.W(10), .AW(16)) dut (
      .CLK(CLK), .Clear(Clear), .Load(Load), .Ready(Ready), .Data(Data), .Mode(Mode),
      .Acc_en(Acc_en), .Flush(Flush), .Valid(Valid), .Out_ready(Out_ready),
      .Count(Count), .Total(Total), .Sat(Sat)
   );

   tc_stream #(.W(10), .AW(4)) dut4 (
      .CLK(CLK), .Clear(Clear), .Load(Load), .Ready(ready4), .Data(Data), .Mode(Mode),
      .Acc_en(Acc_en), .Flush(Flush), .Valid(valid4), .Out_ready(Out_ready),
      .Count(count4), .Total(total4), .Sat(sat4)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic reset_dut();
      Clear = 1'b0;
      #2;
      Clear = 1'b1;
      step();
   endtask

   initial begin
      // Reset state
      #1;
      chk("rst_valid", 64'(Valid), 64'd0);
      chk("rst_count", 64'(Count), 64'd0);
      chk("rst_total", 64'(Total), 64'd0);
      chk("rst_sat",   64'(Sat),   64'd0);
      chk("rst_ready", 64'(Ready), 64'd0);
      step();
      chk("rst_ready_held", 64'(Ready), 64'd0);
      Clear = 1'b1;
      step();
      chk("ready_after_release", 64'(Ready), 64'd1);

      // Single word, mode 00: count 9, one-cycle Valid on the second edge
      Data = ALT; Mode = 2'b00; Load = 1'b1;
      step();
      Load = 1'b0;
      chk("single_lat1_valid", 64'(Valid), 64'd0);
      step();
      chk("single_valid", 64'(Valid), 64'd1);
      chk("single_count", 64'(Count), 64'd9);
      step();
      chk("single_valid_drop", 64'(Valid), 64'd0);

      // Back-to-back modes 00/01/10: 3 consecutive results 9,4,5
      Load = 1'b1; Mode = 2'b00;
      step();
      Mode = 2'b01;
      step();
      chk("b2b_v0", 64'(Valid), 64'd1);
      chk("b2b_c0", 64'(Count), 64'd9);
      Mode = 2'b10;
      step();
      Load = 1'b0;
      chk("b2b_v1", 64'(Valid), 64'd1);
      chk("b2b_c1", 64'(Count), 64'd4);
      step();
      chk("b2b_v2", 64'(Valid), 64'd1);
      chk("b2b_c2", 64'(Count), 64'd5);
      step();
      chk("b2b_end", 64'(Valid), 64'd0);

      // Chain mode: 3FF then 000 after reset gives 0 then 1
      reset_dut();
      Mode = 2'b11; Data = 10'h3FF; Load = 1'b1;
      step();
      Data = 10'h000;
      step();
      Load = 1'b0;
      chk("chain_c0", 64'(Count), 64'd0);
      step();
      chk("chain_v1", 64'(Valid), 64'd1);
      chk("chain_c1", 64'(Count), 64'd1);

      // Chain mode with Flush between words: 0 then 0
      reset_dut();
      Data = 10'h3FF; Load = 1'b1;
      step();
      Load = 1'b0; Flush = 1'b1;
      step();
      Flush = 1'b0;
      chk("chainf_c0", 64'(Count), 64'd0);
      Data = 10'h000; Load = 1'b1;
      step();
      Load = 1'b0;
      step();
      chk("chainf_v1", 64'(Valid), 64'd1);
      chk("chainf_c1", 64'(Count), 64'd0);

      // Accumulation: AW=4 saturates at 15, AW=16 reaches 18
      reset_dut();
      Mode = 2'b00; Data = ALT; Acc_en = 1'b1; Load = 1'b1;
      step();
      step();
      Load = 1'b0;
      chk("acc4_t0",  64'(total4), 64'd9);
      chk("acc4_s0",  64'(sat4),   64'd0);
      chk("acc16_t0", 64'(Total),  64'd9);
      step();
      chk("acc4_t1",  64'(total4), 64'd15);
      chk("acc4_s1",  64'(sat4),   64'd1);
      chk("acc16_t1", 64'(Total),  64'd18);
      chk("acc16_s1", 64'(Sat),    64'd0);
      Acc_en = 1'b0; Flush = 1'b1;
      step();
      Flush = 1'b0;
      chk("flush_t4", 64'(total4), 64'd0);
      chk("flush_s4", 64'(sat4),   64'd0);
      chk("flush_t",  64'(Total),  64'd0);

      // Flush on the accumulation edge wins, Count still delivered
      Acc_en = 1'b1; Load = 1'b1;
      step();
      Load = 1'b0; Flush = 1'b1;
      step();
      Flush = 1'b0; Acc_en = 1'b0;
      chk("flushacc_v", 64'(Valid), 64'd1);
      chk("flushacc_c", 64'(Count), 64'd9);
      chk("flushacc_t", 64'(Total), 64'd0);
      step();

      // Back-pressure: two accepts, then Ready low and Count held
      reset_dut();
      Out_ready = 1'b0; Data = ALT; Mode = 2'b00; Load = 1'b1;
      chk("bp_ready0", 64'(Ready), 64'd1);
      step();
      Mode = 2'b01;
      chk("bp_ready1", 64'(Ready), 64'd1);
      step();
      Mode = 2'b10;
      for (int i = 0; i < 3; i++) begin
         chk("bp_ready_low", 64'(Ready), 64'd0);
         chk("bp_valid",     64'(Valid), 64'd1);
         chk("bp_count",     64'(Count), 64'd9);
         step();
      end
      Out_ready = 1'b1;
      #1;
      chk("bp_ready_rel", 64'(Ready), 64'd1);
      step();
      Load = 1'b0;
      chk("bp_v1", 64'(Valid), 64'd1);
      chk("bp_c1", 64'(Count), 64'd4);
      step();
      chk("bp_v2", 64'(Valid), 64'd1);
      chk("bp_c2", 64'(Count), 64'd5);
      step();
      chk("bp_end", 64'(Valid), 64'd0);

      // Clear mid-flight with two words in the pipe
      Mode = 2'b00; Acc_en = 1'b1; Load = 1'b1;
      step();
      step();
      Load = 1'b0;
      chk("clr_pre_total", 64'(Total), 64'd9);
      #1;
      Clear = 1'b0;
      #1;
      chk("clr_valid", 64'(Valid), 64'd0);
      chk("clr_total", 64'(Total), 64'd0);
      chk("clr_ready", 64'(Ready), 64'd0);
      #2;
      Clear = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("clr_no_stale", 64'(Valid), 64'd0);
      end
      chk("clr_total_after", 64'(Total), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
